// File: rtl/servo_pos_ctrl_if.sv
// Bundle between the position controller and its environment: target input,
// driver handshake and status outputs.
`timescale 1ns/1ps
interface servo_pos_ctrl_if;
  logic        i_target_valid;
  logic [7:0]  i_target;
  logic        i_done;
  logic        o_start;
  logic [31:0] o_pulseWidth;
  logic        o_at_goal;
  logic        o_overrun;
  logic        o_fault;

  modport slave (
    input  i_target_valid, i_target, i_done,
    output o_start, o_pulseWidth, o_at_goal, o_overrun, o_fault
  );

  modport master (
    output i_target_valid, i_target, i_done,
    input  o_start, o_pulseWidth, o_at_goal, o_overrun, o_fault
  );
endinterface

// File: rtl/servo_pos_ctrl.sv
// Servo position controller: maps an 8-bit target to a slew-limited pulse width
// and issues one start per frame to the PWM driver, watching its done flag.
`timescale 1ns/1ps
module servo_pos_ctrl #(
  parameter int unsigned T_CLK       = 10,
  parameter int unsigned PERIOD_US   = 20000,
  parameter int unsigned MIN_US      = 1000,
  parameter int unsigned MAX_US      = 2000,
  parameter int unsigned STEP_US     = 100,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  servo_pos_ctrl_if.slave   bus
);

  localparam logic [31:0] PERIOD_CYC = 32'(PERIOD_US * 1000 / T_CLK);
  localparam logic [31:0] MIN_CYC    = 32'(MIN_US * 1000 / T_CLK);
  localparam logic [31:0] MAX_CYC    = 32'(MAX_US * 1000 / T_CLK);
  localparam logic [31:0] STEP_CYC   = 32'(STEP_US * 1000 / T_CLK);
  localparam logic [31:0] SPAN_CYC   = MAX_CYC - MIN_CYC;
  localparam logic [31:0] CENTER_CYC = MIN_CYC + (SPAN_CYC >> 1);
  localparam logic [31:0] ACK_LAST   = 32'(ACK_TIMEOUT - 1);

  localparam logic [1:0] WAIT_TICK = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_ACK  = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  if (!(PERIOD_US > MAX_US && MAX_US > MIN_US && STEP_CYC >= 32'd1)) begin : g_param_check
    $fatal(1, "servo_pos_ctrl: inconsistent timing parameters");
  end

  logic [1:0]  state_r;
  logic [31:0] cnt_r;
  logic [31:0] ack_cnt_r;
  logic [31:0] goal_r;
  logic [31:0] cur_r;
  logic [31:0] pw_r;
  logic        start_r;
  logic        overrun_r;
  logic        fault_r;
  logic        at_goal_r;

  logic        tick_s;
  logic        issue_s;
  logic [39:0] prod_s;
  logic [31:0] map_s;
  logic [31:0] step_s;
  logic [31:0] goal_nxt_s;
  logic [31:0] cur_nxt_s;

  assign tick_s  = (cnt_r == PERIOD_CYC - 32'd1);
  assign issue_s = tick_s && (state_r == WAIT_TICK) && bus.i_done;

  // Target-to-width mapping, 40-bit product truncated toward zero.
  assign prod_s = 40'(bus.i_target) * 40'(SPAN_CYC);
  assign map_s  = MIN_CYC + 32'(prod_s >> 8);

  // Slew step toward the goal, never overshooting it.
  always_comb begin
    step_s = cur_r;
    if (goal_r > cur_r) begin
      if ((goal_r - cur_r) > STEP_CYC) step_s = cur_r + STEP_CYC;
      else                            step_s = goal_r;
    end else if (goal_r < cur_r) begin
      if ((cur_r - goal_r) > STEP_CYC) step_s = cur_r - STEP_CYC;
      else                            step_s = goal_r;
    end else begin
      step_s = cur_r;
    end
  end

  // Next goal/current width; the step above always sees the pre-edge goal.
  always_comb begin
    goal_nxt_s = goal_r;
    cur_nxt_s  = cur_r;
    if (bus.i_target_valid) goal_nxt_s = map_s;
    else                    goal_nxt_s = goal_r;
    if (issue_s) cur_nxt_s = step_s;
    else         cur_nxt_s = cur_r;
  end

  // Frame counter, width registers, status outputs and driver handshake FSM.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r   <= WAIT_TICK;
      cnt_r     <= 32'd0;
      ack_cnt_r <= 32'd0;
      goal_r    <= CENTER_CYC;
      cur_r     <= CENTER_CYC;
      pw_r      <= CENTER_CYC;
      start_r   <= 1'b0;
      overrun_r <= 1'b0;
      fault_r   <= 1'b0;
      at_goal_r <= 1'b1;
    end else begin
      cnt_r     <= tick_s ? 32'd0 : cnt_r + 32'd1;
      goal_r    <= goal_nxt_s;
      cur_r     <= cur_nxt_s;
      at_goal_r <= (cur_nxt_s == goal_nxt_s);
      start_r   <= issue_s;
      overrun_r <= tick_s && !issue_s;
      if (issue_s) pw_r <= step_s;
      case (state_r)
        WAIT_TICK: begin
          if (issue_s) state_r <= ISSUE;
        end
        ISSUE: begin
          state_r   <= WAIT_ACK;
          ack_cnt_r <= 32'd0;
        end
        WAIT_ACK: begin
          if (!bus.i_done) begin
            state_r <= WAIT_DONE;
          end else if (ack_cnt_r == ACK_LAST) begin
            state_r <= WAIT_TICK;
            fault_r <= 1'b1;
          end else begin
            ack_cnt_r <= ack_cnt_r + 32'd1;
          end
        end
        WAIT_DONE: begin
          if (bus.i_done) state_r <= WAIT_TICK;
        end
        default: state_r <= WAIT_TICK;
      endcase
    end
  end

  assign bus.o_start      = start_r;
  assign bus.o_pulseWidth = pw_r;
  assign bus.o_at_goal    = at_goal_r;
  assign bus.o_overrun    = overrun_r;
  assign bus.o_fault      = fault_r;

endmodule

// File: doc/servo_pos_ctrl.md
# servo_pos_ctrl

Position controller that sits directly upstream of the servo PWM driver. It converts an 8-bit target position into a pulse-width count in clock cycles and slew-limits the commanded width. Once per servo frame (default 20 ms) it issues a single-cycle start to the driver, then tracks the driver's done/idle flag to detect overruns and a driver that never responds.

## Interface
Parameters:
- T_CLK, 10: clock period in ns; all *_US parameters are converted to cycles as US*1000/T_CLK.
- PERIOD_US, 20000: frame period; PERIOD_CYC = PERIOD_US*1000/T_CLK.
- MIN_US, 1000: pulse width at target 0; MIN_CYC.
- MAX_US, 2000: full-scale pulse width; SPAN_CYC = MAX_CYC - MIN_CYC.
- STEP_US, 100: maximum width change per frame; STEP_CYC.
- ACK_TIMEOUT, 4: cycles allowed for the driver to drop done after a start.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_target_valid  in  1  qualifies i_target for one cycle
- i_target  in  8  requested position; 0 = MIN, 255 = near MAX
- i_done  in  1  driver idle/done flag (high = idle)
- o_start  out  1  single-cycle start pulse to the driver
- o_pulseWidth  out  32  pulse width in clock cycles; stable between starts
- o_at_goal  out  1  current commanded width equals goal
- o_overrun  out  1  one-cycle pulse when a frame is skipped
- o_fault  out  1  sticky driver no-acknowledge flag

## Operation
- Elaboration check: PERIOD_US > MAX_US, MAX_US > MIN_US, STEP_CYC >= 1; otherwise $fatal.
- Reset values (asynchronous, immediate):
  - o_start=0, o_overrun=0, o_fault=0.
  - goal = cur = o_pulseWidth = CENTER_CYC = MIN_CYC + SPAN_CYC/2.
  - o_at_goal=1, frame counter=0, state=WAIT_TICK.
- Goal mapping: when i_target_valid is high, goal <= MIN_CYC + ((i_target*SPAN_CYC) >> 8) on the same edge.
  - Product is computed at 40 bits minimum and truncated toward zero.
  - The last valid target wins; there is no backpressure.
- Frame counter: counts 0..PERIOD_CYC-1 and wraps. tick = (counter == PERIOD_CYC-1).
- FSM states: WAIT_TICK, ISSUE, WAIT_ACK, WAIT_DONE.
  - WAIT_TICK, tick and i_done=1 → ISSUE.
    - On the same edge: cur <= step(cur, goal), o_pulseWidth <= step(cur, goal), o_start <= 1.
  - WAIT_TICK, tick and i_done=0 → stay. o_overrun pulses; cur is unchanged.
  - ISSUE → WAIT_ACK. o_start returns to 0; ack counter cleared.
  - WAIT_ACK, i_done=0 → WAIT_DONE.
  - WAIT_ACK, ACK_TIMEOUT cycles elapse with i_done=1 → WAIT_TICK. o_fault <= 1.
  - WAIT_DONE, i_done=1 → WAIT_TICK.
  - Tick in any state other than WAIT_TICK: o_overrun pulses and no start is issued for that frame.
- step(cur, goal):
  - goal > cur: cur + min(STEP_CYC, goal - cur).
  - goal < cur: cur - min(STEP_CYC, cur - goal).
  - otherwise cur.
  - Unsigned; never crosses goal.
- o_fault is cleared only by reset. Frames continue to be issued while it is set.
- o_at_goal = (cur == goal), decoded from registers.

## Timing
- First tick occurs on the PERIOD_CYC-th rising edge after i_rst deasserts. o_start is high for exactly the following cycle.
- Start spacing is exactly PERIOD_CYC cycles when no frames are skipped.
- o_pulseWidth changes on the same edge that raises o_start and holds until the next start.
- Target-to-effect latency: a goal captured on edge N is used by the first tick at or after edge N+1.
- Target valid coincident with tick: the step uses the old goal; the new goal applies from the next frame.
- Reset asserted mid-frame or mid-handshake: all outputs return to reset values asynchronously. o_start never glitches high.

## Test plan
All scenarios use T_CLK=10, PERIOD_US=3000, MIN_US=1000, MAX_US=2000, STEP_US=100 (PERIOD_CYC=300000, SPAN_CYC=100000, STEP_CYC=10000, CENTER_CYC=150000). The driver model drops i_done 1 cycle after o_start and raises it o_pulseWidth cycles later.

- Reset/first frame: release reset with no target. o_pulseWidth=150000 and o_at_goal=1 throughout. First o_start occurs 300000 edges after release; subsequent starts are 300000 apart with width 150000.
- Slew up: i_target=255 gives goal 199609. Successive starts carry 160000, 170000, 180000, 190000, 199609. o_at_goal rises with the 199609 start.
- Slew down, with a retarget mid-slew:
  - i_target=0 gives starts at 140000, 130000.
  - i_target=128 then sets goal 150000; the next starts carry 140000, 150000 and then hold.
- Fault: the driver ignores o_start (i_done stays 1). o_fault rises 4 cycles after the ISSUE cycle and stays high. Starts continue every 300000 cycles.
- Overrun: the driver holds i_done=0 across a tick. o_overrun is a single-cycle pulse, no o_start is issued that frame, and o_pulseWidth is unchanged. Normal starts resume at the next tick after i_done returns high.
- Async reset: assert i_rst in WAIT_DONE at width 180000. o_pulseWidth becomes 150000 and o_start/o_fault/o_overrun become 0 immediately (before the next clock edge). The frame restarts from counter 0.
